// File: rtl/arm_mc_controller.sv
// arm_mc_controller: multicycle control unit for the ARM datapath.
// Sequences each instruction through FETCH/DECODE/execute/memory/writeback,
// holds the NZCV flag register and evaluates ARM condition codes.
//
// Handshake / timing contract with the datapath: there is no valid/ready
// pair here; every write enable is a one-cycle strobe that the datapath
// samples at the rising clock edge ending the cycle in which it is high.
// Instr is the instruction register, which the datapath loads at the edge
// ending FETCH (IRWrite=1), so Instr is stable from DECODE onward.
//
// All datapath controls are registered: the next state's output values are
// computed from next_state and loaded together with the state register, so
// outputs never depend combinationally on ALUFlags. Only the write enables
// are additionally gated by reset (and by state legality) so that a reset
// suppresses writes in the very cycle it is asserted.
module arm_mc_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        AdrSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUControl,
  output logic [3:0]  Flags,
  output logic [3:0]  State
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_4   = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  // Instruction fields
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       unused_instr_bits;

  assign cond  = Instr[31:28];
  assign op    = Instr[27:26];
  assign funct = Instr[25:20];
  assign rd    = Instr[15:12];
  assign unused_instr_bits = ^{Instr[19:16], Instr[11:0]};

  // Architectural state
  state_t     state;
  state_t     next_state;
  logic [3:0] flags_q;
  logic       condexd_q;

  // Registered datapath controls (values for the current state)
  logic       pcw_q;
  logic       irw_q;
  logic       rw_q;
  logic       mw_q;
  logic       adrsrc_q;
  logic       srca_q;
  logic [1:0] srcb_q;
  logic [1:0] ressrc_q;
  logic [1:0] aluctl_q;

  // Next-cycle control values
  logic       n_pcw;
  logic       n_irw;
  logic       n_rw;
  logic       n_mw;
  logic       n_adrsrc;
  logic       n_srca;
  logic [1:0] n_srcb;
  logic [1:0] n_ressrc;
  logic [1:0] n_aluctl;

  // Decode results
  logic [1:0] dp_alu;
  logic       dp_wb;
  logic [1:0] flagw;
  logic       condex;
  logic       condexd_next;
  logic       state_legal;

  // ALU decoder: data-processing command to ALU op, writeback and flag-write masks
  always_comb begin
    dp_alu = ALU_ADD;
    dp_wb  = 1'b0;
    flagw  = 2'b00;
    case (funct[4:1])
      4'b0100: begin
        dp_alu = ALU_ADD;
        dp_wb  = 1'b1;
        flagw  = {funct[0], funct[0]};
      end
      4'b0010: begin
        dp_alu = ALU_SUB;
        dp_wb  = 1'b1;
        flagw  = {funct[0], funct[0]};
      end
      4'b0000: begin
        dp_alu = ALU_AND;
        dp_wb  = 1'b1;
        flagw  = {funct[0], 1'b0};
      end
      4'b1100: begin
        dp_alu = ALU_ORR;
        dp_wb  = 1'b1;
        flagw  = {funct[0], 1'b0};
      end
      4'b1010: begin
        // CMP always sets all four flags and never writes a register
        dp_alu = ALU_SUB;
        dp_wb  = 1'b0;
        flagw  = 2'b11;
      end
      default: begin
        // Unsupported command behaves as a NOP
        dp_alu = ALU_ADD;
        dp_wb  = 1'b0;
        flagw  = 2'b00;
      end
    endcase
  end

  // Condition check against the registered NZCV flags
  always_comb begin
    logic fn;
    logic fz;
    logic fc;
    logic fv;
    {fn, fz, fc, fv} = flags_q;
    condex = 1'b0;
    case (cond)
      4'b0000: condex = fz;
      4'b0001: condex = ~fz;
      4'b0010: condex = fc;
      4'b0011: condex = ~fc;
      4'b0100: condex = fn;
      4'b0101: condex = ~fn;
      4'b0110: condex = fv;
      4'b0111: condex = ~fv;
      4'b1000: condex = fc & ~fz;
      4'b1001: condex = ~fc | fz;
      4'b1010: condex = (fn == fv);
      4'b1011: condex = (fn != fv);
      4'b1100: condex = ~fz & (fn == fv);
      4'b1101: condex = fz | (fn != fv);
      4'b1110: condex = 1'b1;
      default: condex = 1'b0;
    endcase
  end

  // CondExD as it will be after this edge: latched only when leaving DECODE
  assign condexd_next = (state == S_DECODE) ? condex : condexd_q;

  // Next-state selection
  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        case (op)
          2'b00:   next_state = funct[5] ? S_EXECI : S_EXECR;
          2'b01:   next_state = S_MEMADR;
          2'b10:   next_state = S_BRANCH;
          default: next_state = S_FETCH;
        endcase
      end
      S_MEMADR: next_state = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  next_state = S_MEMWB;
      S_MEMWB:  next_state = S_FETCH;
      S_MEMWR:  next_state = S_FETCH;
      S_EXECR:  next_state = S_ALUWB;
      S_EXECI:  next_state = S_ALUWB;
      S_ALUWB:  next_state = S_FETCH;
      S_BRANCH: next_state = S_FETCH;
      default:  next_state = S_FETCH;
    endcase
  end

  // Control values for the state being entered at the next edge
  always_comb begin
    n_pcw    = 1'b0;
    n_irw    = 1'b0;
    n_rw     = 1'b0;
    n_mw     = 1'b0;
    n_adrsrc = 1'b0;
    n_srca   = 1'b0;
    n_srcb   = SRCB_REG;
    n_ressrc = RES_ALUOUT;
    n_aluctl = ALU_ADD;
    case (next_state)
      S_FETCH: begin
        n_adrsrc = 1'b0;
        n_irw    = 1'b1;
        n_srca   = 1'b1;
        n_srcb   = SRCB_4;
        n_ressrc = RES_ALURES;
        n_pcw    = 1'b1;
      end
      S_DECODE: begin
        // PC+4 again, i.e. PC+8 of this instruction, for R15 reads
        n_srca   = 1'b1;
        n_srcb   = SRCB_4;
        n_ressrc = RES_ALURES;
      end
      S_MEMADR: begin
        n_srcb   = SRCB_IMM;
        n_aluctl = funct[3] ? ALU_ADD : ALU_SUB;
      end
      S_MEMRD: begin
        n_adrsrc = 1'b1;
      end
      S_MEMWB: begin
        n_ressrc = RES_DATA;
        n_rw     = condexd_next;
        n_pcw    = condexd_next & (rd == 4'd15);
      end
      S_MEMWR: begin
        n_adrsrc = 1'b1;
        n_mw     = condexd_next;
      end
      S_EXECR: begin
        n_srcb   = SRCB_REG;
        n_aluctl = dp_alu;
      end
      S_EXECI: begin
        n_srcb   = SRCB_IMM;
        n_aluctl = dp_alu;
      end
      S_ALUWB: begin
        n_ressrc = RES_ALUOUT;
        n_rw     = condexd_next & dp_wb;
        n_pcw    = condexd_next & dp_wb & (rd == 4'd15);
      end
      S_BRANCH: begin
        n_srcb   = SRCB_IMM;
        n_aluctl = ALU_ADD;
        n_ressrc = RES_ALURES;
        n_pcw    = condexd_next;
      end
      default: begin
        n_pcw = 1'b0;
      end
    endcase
  end

  // FSM, CondExD, flag register and registered controls
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      flags_q   <= 4'b0000;
      condexd_q <= 1'b0;
      // Preload FETCH controls so the first cycle after reset fetches
      pcw_q     <= 1'b1;
      irw_q     <= 1'b1;
      rw_q      <= 1'b0;
      mw_q      <= 1'b0;
      adrsrc_q  <= 1'b0;
      srca_q    <= 1'b1;
      srcb_q    <= SRCB_4;
      ressrc_q  <= RES_ALURES;
      aluctl_q  <= ALU_ADD;
    end else begin
      state     <= next_state;
      condexd_q <= condexd_next;
      if (((state == S_EXECR) || (state == S_EXECI)) && condexd_q) begin
        if (flagw[1]) flags_q[3:2] <= ALUFlags[3:2];
        if (flagw[0]) flags_q[1:0] <= ALUFlags[1:0];
      end
      pcw_q    <= n_pcw;
      irw_q    <= n_irw;
      rw_q     <= n_rw;
      mw_q     <= n_mw;
      adrsrc_q <= n_adrsrc;
      srca_q   <= n_srca;
      srcb_q   <= n_srcb;
      ressrc_q <= n_ressrc;
      aluctl_q <= n_aluctl;
    end
  end

  // An illegal state code (10-15) must never write anything
  assign state_legal = (state <= S_BRANCH);

  assign PCWrite    = pcw_q & ~reset & state_legal;
  assign IRWrite    = irw_q & ~reset & state_legal;
  assign RegWrite   = rw_q  & ~reset & state_legal;
  assign MemWrite   = mw_q  & ~reset & state_legal;
  assign AdrSrc     = adrsrc_q;
  assign ALUSrcA    = srca_q;
  assign ALUSrcB    = srcb_q;
  assign ResultSrc  = ressrc_q;
  assign ALUControl = aluctl_q;
  assign ImmSrc     = op;
  assign RegSrc     = {op == 2'b01, op == 2'b10};
  assign Flags      = flags_q;
  assign State      = state;

endmodule

// File: tb/tb_arm_mc_controller.sv
// Testbench for arm_mc_controller: directed instruction sequences plus
// randomized instructions, checked cycle by cycle against a per-instruction
// reference model that derives state sequences and outputs from ISA rules.
module tb_arm_mc_controller;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA;
  logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;
  logic [3:0]  Flags, State;

  arm_mc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .PCWrite    (PCWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .AdrSrc     (AdrSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .ALUControl (ALUControl),
    .Flags      (Flags),
    .State      (State)
  );

  localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4;
  localparam int MEMWR = 5, EXECR = 6, EXECI = 7, ALUWB = 8, BRANCH = 9;

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [23:0] exp_q[$];

  // Model state: flags the DUT should hold and the instruction register
  logic [3:0]  m_flags;
  logic [31:0] m_ir;

  task automatic check_val(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (State,PCW,IRW,RW,MW,Adr,SrcA,SrcB,Res,Imm,RegSrc,ALU,Flags)",
               tag, got, exp);
    end
  endtask

  function automatic logic [23:0] dut_vec();
    return {State, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
            ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, Flags};
  endfunction

  // ARM condition semantics on NZCV
  function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Data-processing command table: {alu op, writes Rd, updates NZ, updates CV}
  function automatic logic [4:0] dp_info(input logic [5:0] funct);
    logic s;
    s = funct[0];
    case (funct[4:1])
      4'b0100: return {2'b00, 1'b1, s, s};     // ADD
      4'b0010: return {2'b01, 1'b1, s, s};     // SUB
      4'b0000: return {2'b10, 1'b1, s, 1'b0};  // AND
      4'b1100: return {2'b11, 1'b1, s, 1'b0};  // ORR
      4'b1010: return {2'b01, 1'b0, 1'b1, 1'b1}; // CMP
      default: return 5'b00000;                // NOP
    endcase
  endfunction

  // Expected outputs for a given state, IR contents, condition outcome and flags
  function automatic logic [23:0] expect_vec(input int st, input logic [31:0] ir,
                                             input bit ce, input logic [3:0] fl, input bit rst);
    logic pcw, irw, rw, mw, adr, sa;
    logic [1:0] sb, rs, alu, op;
    logic [4:0] d;
    logic [3:0] st4;
    bit r15;
    pcw = 0; irw = 0; rw = 0; mw = 0; adr = 0; sa = 0;
    sb = 2'b00; rs = 2'b00; alu = 2'b00;
    op = ir[27:26];
    d = dp_info(ir[25:20]);
    r15 = (ir[15:12] == 4'd15);
    case (st)
      FETCH:  begin irw = 1; sa = 1; sb = 2'b10; rs = 2'b10; pcw = 1; end
      DECODE: begin sa = 1; sb = 2'b10; rs = 2'b10; end
      MEMADR: begin sb = 2'b01; alu = ir[23] ? 2'b00 : 2'b01; end
      MEMRD:  begin adr = 1; end
      MEMWB:  begin rs = 2'b01; rw = ce; pcw = ce && r15; end
      MEMWR:  begin adr = 1; mw = ce; end
      EXECR:  begin alu = d[4:3]; end
      EXECI:  begin sb = 2'b01; alu = d[4:3]; end
      ALUWB:  begin rw = ce && d[2]; pcw = ce && d[2] && r15; end
      BRANCH: begin sb = 2'b01; rs = 2'b10; pcw = ce; end
      default: ;
    endcase
    if (rst) begin pcw = 0; irw = 0; rw = 0; mw = 0; end
    st4 = st[3:0];
    return {st4, pcw, irw, rw, mw, adr, sa, sb, rs, op,
            (op == 2'b01), (op == 2'b10), alu, fl};
  endfunction

  // ---------------- driver ----------------
  // Runs one instruction cycle by cycle. exec_flags >= 0 forces ALUFlags in
  // the execute cycle; abort_idx >= 0 asserts reset in that cycle of the
  // instruction, which ends it.
  task automatic run_instr(input string name, input logic [31:0] ins,
                           input int exec_flags, input int abort_idx);
    int sts[$];
    bit ce;
    logic [3:0] aluf;
    logic [4:0] d;
    logic [23:0] e;
    bit rst;
    sts = {FETCH, DECODE};
    case (ins[27:26])
      2'b00: sts = {sts, (ins[25] ? EXECI : EXECR), ALUWB};
      2'b01: sts = ins[20] ? {sts, MEMADR, MEMRD, MEMWB} : {sts, MEMADR, MEMWR};
      2'b10: sts = {sts, BRANCH};
      default: ;
    endcase
    ce = cond_holds(ins[31:28], m_flags);
    d = dp_info(ins[25:20]);
    foreach (sts[i]) begin
      int st;
      st = sts[i];
      aluf = 4'($urandom_range(0, 15));
      if ((st == EXECR || st == EXECI) && exec_flags >= 0) aluf = exec_flags[3:0];
      rst = (i == abort_idx);
      Instr = (st == FETCH) ? m_ir : ins;
      ALUFlags = aluf;
      reset = rst;
      e = expect_vec(st, Instr, ce, m_flags, rst);
      exp_q.push_back(e);
      @(negedge clk);
      check_val($sformatf("%s cyc%0d", name, i), dut_vec(), exp_q.pop_front());
      if (st == FETCH && !rst) m_ir = ins;
      if (rst) m_flags = 4'b0000;
      else if ((st == EXECR || st == EXECI) && ce) begin
        if (d[1]) m_flags[3:2] = aluf[3:2];
        if (d[0]) m_flags[1:0] = aluf[1:0];
      end
      @(posedge clk);
      #1;
      if (rst) begin
        reset = 1'b0;
        break;
      end
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [3:0] cmds [5];
    cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
    r = $urandom;
    if ($urandom_range(0, 1) == 1) r[24:21] = cmds[$urandom_range(0, 4)];
    if ($urandom_range(0, 3) == 0) r[15:12] = 4'd15;
    if ($urandom_range(0, 2) == 0) r[31:28] = 4'hE;
    return r;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1;
    Instr = 32'h0;
    ALUFlags = 4'h0;
    m_flags = 4'h0;
    m_ir = 32'h0;

    // Two reset edges; check held-in-reset outputs during the second cycle
    @(posedge clk); #1;
    @(negedge clk);
    check_val("in_reset", dut_vec(), expect_vec(FETCH, 32'h0, 1'b0, 4'h0, 1'b1));
    @(posedge clk); #1;
    reset = 1'b0;

    // ADDS R1: flags become 0100
    run_instr("adds", {4'hE, 2'b00, 6'b001001, 4'd2, 4'd1, 12'h003}, 4, -1);
    check_val("adds_flags", {20'h0, Flags}, {20'h0, 4'b0100});
    // CMP with Z=1 then BEQ taken
    run_instr("cmp_z1", {4'hE, 2'b00, 6'b010101, 4'd1, 4'd0, 12'h002}, 6, -1);
    run_instr("beq_t", {4'h0, 2'b10, 26'h0000010}, -1, -1);
    // CMP with Z=0 then BEQ not taken
    run_instr("cmp_z0", {4'hE, 2'b00, 6'b010101, 4'd1, 4'd0, 12'h002}, 0, -1);
    run_instr("beq_nt", {4'h0, 2'b10, 26'h0000010}, -1, -1);
    // LDR with down offset, then LDR to R15
    run_instr("ldr", {4'hE, 2'b01, 6'b010001, 4'd0, 4'd3, 12'h004}, -1, -1);
    run_instr("ldr_pc", {4'hE, 2'b01, 6'b010001, 4'd0, 4'd15, 12'h004}, -1, -1);
    // Set Z, then STRNE must not write
    run_instr("cmp_z", {4'hE, 2'b00, 6'b010101, 4'd1, 4'd0, 12'h002}, 4, -1);
    run_instr("strne", {4'h1, 2'b01, 6'b011000, 4'd0, 4'd2, 12'h008}, -1, -1);
    // Undefined instruction
    run_instr("undef", {4'hE, 2'b11, 26'h1234567}, -1, -1);
    // Reset during MEMWR of an STR
    run_instr("str_abort", {4'hE, 2'b01, 6'b011000, 4'd0, 4'd2, 12'h008}, -1, 3);
    check_val("abort_flags", {20'h0, Flags}, 24'h0);
    run_instr("after_abort", {4'hE, 2'b00, 6'b101001, 4'd2, 4'd1, 12'h0FF}, -1, -1);

    // Randomized instructions, occasionally aborted by reset
    for (int k = 0; k < 400; k++) begin
      int ab;
      ab = ($urandom_range(0, 29) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr($sformatf("rnd%0d", k), rand_instr(), -1, ab);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
